instr_decode_queue: RTL and testbench

Parametrised instruction decode queue between fetch and execute. Buffers up to DEPTH fetched instructions with their PCs behind a valid/ready handshake. Presents the head entry fully split into MIPS fields, plus sign- and zero-extended immediates and a computed jump target. Supports flush for branch redirect.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/instr_fifo_mem.sv | 82 ++++++++
 rtl/instr_decode_queue.sv | 104 ++++++++++
 tb/tb_instr_decode_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// MIPS instruction field layout shared by decode-stage blocks.
// Bit positions, the R-type opcode and a one-call field splitter.
package mips_pkg;

    localparam int INSTR_W    = 32;

    localparam int OPC_MSB    = 31;
    localparam int OPC_LSB    = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SA_MSB     = 10;
    localparam int SA_LSB     = 6;
    localparam int FUN_MSB    = 5;
    localparam int FUN_LSB    = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int IINDEX_MSB = 25;
    localparam int IINDEX_LSB = 0;

    localparam logic [5:0] OPC_RTYPE = 6'h00;

    typedef struct packed {
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [5:0]  fun;
        logic [15:0] imm;
        logic [25:0] iindex;
    } mips_fields_t;

    function automatic mips_fields_t mips_decode(input logic [INSTR_W-1:0] instr);
        mips_fields_t f;
        f.opc    = instr[OPC_MSB:OPC_LSB];
        f.rs     = instr[RS_MSB:RS_LSB];
        f.rt     = instr[RT_MSB:RT_LSB];
        f.rd     = instr[RD_MSB:RD_LSB];
        f.sa     = instr[SA_MSB:SA_LSB];
        f.fun    = instr[FUN_MSB:FUN_LSB];
        f.imm    = instr[IMM_MSB:IMM_LSB];
        f.iindex = instr[IINDEX_MSB:IINDEX_LSB];
        return f;
    endfunction

endpackage

// File: rtl/instr_fifo_mem.sv
// Circular buffer of {instr, pc} entries with read/write pointers and occupancy.
// Flush clears the control state and suppresses any same-cycle push or pop.
module instr_fifo_mem
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [INSTR_W-1:0]           wr_instr,
    input  logic [XLEN-1:0]              wr_pc,
    output logic [INSTR_W-1:0]           rd_instr,
    output logic [XLEN-1:0]              rd_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = INSTR_W + XLEN;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // Defensive gating keeps state intact on an illegal push-when-full / pop-when-empty.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign {rd_instr, rd_pc} = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only: never reset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            mem_q[wr_ptr_q] <= {wr_instr, wr_pc};
        end
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Fetch-to-execute instruction queue presenting the head entry split into MIPS fields,
// extended immediates and a jump target; all head outputs read zero while empty.
module instr_decode_queue
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [XLEN-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [5:0]                   opc,
    output logic [4:0]                   rs,
    output logic [4:0]                   rt,
    output logic [4:0]                   rd,
    output logic [4:0]                   sa,
    output logic [5:0]                   fun,
    output logic [15:0]                  imm,
    output logic [25:0]                  iindex,
    output logic [XLEN-1:0]              imm_sext,
    output logic [XLEN-1:0]              imm_zext,
    output logic [XLEN-1:0]              jtarget,
    output logic                         is_rtype,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    logic               full, empty;
    logic               push, pop;
    logic [31:0]        head_instr;
    logic [XLEN-1:0]    head_pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    jt_mask;
    logic [XLEN-1:0]    jt_low;
    mips_fields_t       f;

    // in_ready comes from registered occupancy only, so a full queue never passes through.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    instr_fifo_mem #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .pop      (pop),
        .wr_instr (in_instr),
        .wr_pc    (in_pc),
        .rd_instr (head_instr),
        .rd_pc    (head_pc),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign f        = mips_decode(head_instr);
    assign pc_plus4 = head_pc + {{(XLEN-3){1'b0}}, 3'd4};
    // Upper bits of PC+4 select the 256 MB region of the delay slot.
    assign jt_mask  = {{(XLEN-28){1'b1}}, 28'h0};
    assign jt_low   = {{(XLEN-28){1'b0}}, f.iindex, 2'b00};

    always_comb begin
        out_pc   = '0;
        opc      = '0;
        rs       = '0;
        rt       = '0;
        rd       = '0;
        sa       = '0;
        fun      = '0;
        imm      = '0;
        iindex   = '0;
        imm_sext = '0;
        imm_zext = '0;
        jtarget  = '0;
        is_rtype = 1'b0;
        if (out_valid) begin
            out_pc   = head_pc;
            opc      = f.opc;
            rs       = f.rs;
            rt       = f.rt;
            rd       = f.rd;
            sa       = f.sa;
            fun      = f.fun;
            imm      = f.imm;
            iindex   = f.iindex;
            imm_sext = {{(XLEN-16){f.imm[15]}}, f.imm};
            imm_zext = {{(XLEN-16){1'b0}}, f.imm};
            jtarget  = (pc_plus4 & jt_mask) | jt_low;
            is_rtype = (f.opc == OPC_RTYPE);
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue (XLEN=32, DEPTH=2) with a reference queue
// for the random-stall ordering run.
module tb_instr_decode_queue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm_sext, imm_zext, jtarget;
    logic [5:0]  opc, fun;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] iindex;
    logic        is_rtype;
    logic [1:0]  count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] qp[$];
    logic [31:0] qi[$];
    logic [31:0] next_pc;
    logic [31:0] exp_instr;
    int          pops;
    logic        iv, orr, mpush, mpop;

    instr_decode_queue #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opc(opc), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .fun(fun), .imm(imm),
        .iindex(iindex), .imm_sext(imm_sext), .imm_zext(imm_zext), .jtarget(jtarget),
        .is_rtype(is_rtype), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction; out_ready chooses whether the current head is popped too.
    task automatic push1(input logic [31:0] instr, input logic [31:0] pc, input logic ordy);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_opc", opc, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_jtarget", jtarget, 0);

        // lw-type word
        push1(32'h8D2A0010, 32'h0040_0000, 1'b0);
        chk("lw_out_valid", out_valid, 1);
        chk("lw_count", count, 1);
        chk("lw_opc", opc, 6'h23);
        chk("lw_rs", rs, 9);
        chk("lw_rt", rt, 10);
        chk("lw_imm", imm, 16'h0010);
        chk("lw_sext", imm_sext, 32'h0000_0010);
        chk("lw_pc", out_pc, 32'h0040_0000);

        // addi with negative immediate; simultaneous push+pop keeps count at 1
        push1(32'h2108FFFF, 32'h0040_0004, 1'b1);
        chk("addi_count", count, 1);
        chk("addi_opc", opc, 6'h08);
        chk("addi_rs", rs, 8);
        chk("addi_rt", rt, 8);
        chk("addi_sext", imm_sext, 32'hFFFF_FFFF);
        chk("addi_zext", imm_zext, 32'h0000_FFFF);
        chk("addi_rtype", is_rtype, 0);
        chk("addi_pc", out_pc, 32'h0040_0004);

        // R-type add
        push1(32'h00221820, 32'h0040_0008, 1'b1);
        chk("add_rtype", is_rtype, 1);
        chk("add_rs", rs, 1);
        chk("add_rt", rt, 2);
        chk("add_rd", rd, 3);
        chk("add_sa", sa, 0);
        chk("add_fun", fun, 6'h20);

        // jumps: plain, upper region, and PC+4 wrapping past 2^32
        push1(32'h08100004, 32'h0040_0000, 1'b1);
        chk("j_iindex", iindex, 26'h010_0004);
        chk("j_target", jtarget, 32'h0040_0010);
        push1(32'h08100004, 32'hF000_0000, 1'b1);
        chk("j_target_hi", jtarget, 32'hF040_0010);
        push1(32'h08100004, 32'hFFFF_FFFC, 1'b1);
        chk("j_target_wrap", jtarget, 32'h0040_0010);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_opc", opc, 0);

        // fill with consumer stalled
        push1(32'h1111_0001, 32'h0000_0100, 1'b0);
        push1(32'h2222_0002, 32'h0000_0104, 1'b0);
        chk("full_count", count, 2);
        chk("full_in_ready", in_ready, 0);
        chk("full_head_pc", out_pc, 32'h0000_0100);
        push1(32'h3333_0003, 32'h0000_0108, 1'b0);
        chk("full_hold_count", count, 2);
        chk("full_hold_pc", out_pc, 32'h0000_0100);
        chk("full_hold_imm", imm, 16'h0001);

        // random-stall ordering run against a reference queue
        qp.push_back(32'h0000_0100); qi.push_back(32'h1111_0001);
        qp.push_back(32'h0000_0104); qi.push_back(32'h2222_0002);
        next_pc = 32'h0000_1000;
        pops = 0;
        for (int cyc = 0; cyc < 3000 && pops < 100; cyc++) begin
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            exp_instr = $urandom;
            in_valid  = iv;
            in_instr  = exp_instr;
            in_pc     = next_pc;
            out_ready = orr;
            mpush = iv && (qp.size() < 2);
            mpop  = orr && (qp.size() > 0);
            if (mpop) begin
                chk("ord_pc", out_pc, qp[0]);
                chk("ord_imm", imm, {48'h0, qi[0][15:0]});
                chk("ord_opc", opc, {58'h0, qi[0][31:26]});
                void'(qp.pop_front());
                void'(qi.pop_front());
                pops++;
            end
            if (mpush) begin
                qp.push_back(next_pc);
                qi.push_back(exp_instr);
                next_pc = next_pc + 32'd4;
            end
            tick();
            chk("ord_count", count, qp.size());
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("ord_transfers", pops, 100);

        // refill to two entries, then flush alongside a push and a pop
        for (int k = 0; k < 4 && count != 2; k++) push1(32'hABCD_0000, 32'h0000_2000, 1'b0);
        chk("pre_flush_count", count, 2);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h5555_5555; in_pc = 32'h0000_3000;
        out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_pc", out_pc, 0);
        push1(32'h00221820, 32'h0000_1234, 1'b0);
        chk("post_flush_pc", out_pc, 32'h0000_1234);
        chk("post_flush_fun", fun, 6'h20);
        chk("post_flush_count", count, 1);

        // reset mid-stream loses the in-flight entry
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        push1(32'h2108FFFF, 32'h0000_4444, 1'b0);
        chk("post_rst_pc", out_pc, 32'h0000_4444);
        chk("post_rst_sext", imm_sext, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
